// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill controller: serves line fetches from the data RAM and refills missed lines
// beat by beat from memory. Optional macro ICACHE_REFILL_FWD_EN forwards the refilled line as a fetch response.
module icache_refill_ctrl #(
  parameter int unsigned ICACHE_NO_OF_SETS = 1024,
  parameter int unsigned ADDR_WIDTH        = $clog2(ICACHE_NO_OF_SETS),
  parameter int unsigned BEAT_WIDTH        = 32,
  parameter int unsigned NUM_BEATS         = 4,
  localparam int unsigned LINE_WIDTH       = NUM_BEATS * BEAT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req_i,
  input  logic [ADDR_WIDTH-1:0] fetch_idx_i,
  output logic                  fetch_ready_o,
  output logic                  fetch_rvalid_o,
  output logic [LINE_WIDTH-1:0] fetch_rdata_o,
  input  logic                  miss_req_i,
  input  logic [31:0]           miss_addr_i,
  output logic                  busy_o,
  output logic                  refill_done_o,
  output logic                  mem_req_o,
  output logic [31:0]           mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [BEAT_WIDTH-1:0] mem_rdata_i,
  output logic                  ram_req_o,
  output logic                  ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [LINE_WIDTH-1:0] ram_wdata_o,
  input  logic [LINE_WIDTH-1:0] ram_rdata_i
);

  localparam int unsigned OFFSET    = $clog2(LINE_WIDTH / 8);
  localparam int unsigned CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [31:0] LINE_MASK = ~((32'd1 << OFFSET) - 32'd1);

  typedef enum logic [1:0] {IDLE, MEM_REQ, COLLECT, WRITE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      beat_cnt;
  logic [LINE_WIDTH-1:0] line_q;
  logic [31:0]           addr_q;
  logic                  rvalid_q;
  logic                  wr_cycle;
  logic                  fetch_acc;

  assign wr_cycle      = (state == WRITE);
  // Qualified with rst_n so no fetch is accepted while reset is held.
  assign fetch_ready_o = rst_n && !wr_cycle;
  assign fetch_acc     = fetch_req_i && fetch_ready_o;

  assign busy_o         = (state != IDLE);
  assign refill_done_o  = wr_cycle;
  assign mem_req_o      = (state == MEM_REQ);
  assign mem_addr_o     = addr_q & LINE_MASK;
  assign fetch_rvalid_o = rvalid_q;
  assign fetch_rdata_o  = rvalid_q ? ram_rdata_i : '0;

  always_comb begin
    ram_req_o   = 1'b0;
    ram_wr_en_o = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (wr_cycle) begin
      ram_req_o   = 1'b1;
      ram_wr_en_o = 1'b1;
      ram_addr_o  = addr_q[OFFSET +: ADDR_WIDTH];
      ram_wdata_o = line_q;
    end else if (fetch_acc) begin
      ram_req_o  = 1'b1;
      ram_addr_o = fetch_idx_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
      line_q   <= '0;
      addr_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
`ifdef ICACHE_REFILL_FWD_EN
      rvalid_q <= fetch_acc || wr_cycle;
`else
      rvalid_q <= fetch_acc;
`endif
      case (state)
        IDLE: begin
          if (miss_req_i) begin
            addr_q <= miss_addr_i;
            state  <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (mem_gnt_i) state <= COLLECT;
        end
        COLLECT: begin
          if (mem_rvalid_i) begin
            line_q[int'(beat_cnt) * BEAT_WIDTH +: BEAT_WIDTH] <= mem_rdata_i;
            if (beat_cnt == CNT_W'(NUM_BEATS - 1)) begin
              beat_cnt <= '0;
              state    <= WRITE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
